// File: rtl/rf_dump_pkg.sv
// Types and sizing constants shared by the register-file dump engine and the regfile.
package rf_dump_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND0,
        ST_SEND1,
        ST_DONE
    } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// Regfile read-port pair plus the (address, data) valid/ready output stream of the dump engine.
interface rf_dump_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_addr;
    logic [WIDTH-1:0] out_data;

    modport master (
        output ra1, ra2, out_valid, out_addr, out_data,
        input  rd1, rd2, out_ready
    );

    modport slave (
        input  ra1, ra2, out_valid, out_addr, out_data,
        output rd1, rd2, out_ready
    );
endinterface

// File: rtl/rf_dump_ctrl.sv
// Walks the register file two registers per fetch and streams (addr, data) words out.
// Optional RF_DUMP_SKIP_X0_EN: omit x0, so the dump starts at x1 and has NREGS-1 words.
module rf_dump_ctrl
    import rf_dump_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    rf_dump_ctrl_if.master bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_PAIR = AW'(NREGS - 2);

    rf_dump_state_t   r_state;
    rf_dump_state_t   w_next;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic [AW-1:0]    w_idx_odd;
    logic             w_last_pair;
    logic             w_skip_even;

    // idx is always even, so OR-ing in bit 0 is idx+1 without a carry chain
    assign w_idx_odd   = r_idx | AW'(1);
    assign w_last_pair = (r_idx == LAST_PAIR);

`ifdef RF_DUMP_SKIP_X0_EN
    assign w_skip_even = (r_idx == '0);
`else
    assign w_skip_even = 1'b0;
`endif

    assign bus.ra1 = r_idx;
    assign bus.ra2 = w_idx_odd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: w_next = w_skip_even ? ST_SEND1 : ST_SEND0;
            ST_SEND0: if (bus.out_ready) w_next = ST_SEND1;
            ST_SEND1: if (bus.out_ready) w_next = w_last_pair ? ST_DONE : ST_FETCH;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_idx <= '0;
            end else if (r_state == ST_SEND1 && bus.out_ready && !w_last_pair) begin
                r_idx <= r_idx + AW'(2);
            end
            // Snapshot point: later regfile writes to this pair are not seen
            if (r_state == ST_FETCH) begin
                r_buf0 <= bus.rd1;
                r_buf1 <= bus.rd2;
            end
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_addr  = '0;
        bus.out_data  = '0;
        busy          = (r_state != ST_IDLE);
        done          = (r_state == ST_DONE);
        case (r_state)
            ST_SEND0: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = r_idx;
                bus.out_data  = r_buf0;
            end
            ST_SEND1: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = w_idx_odd;
                bus.out_data  = r_buf1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Scoreboard bench for rf_dump_ctrl: a behavioural regfile on the read ports, expected words queued at start.
// Build with RF_DUMP_SKIP_X0_EN to check the x0-skipping variant.
module tb_rf_dump_ctrl;
    import rf_dump_pkg::*;

    localparam int W  = RF_WIDTH;
    localparam int N  = RF_NREGS;
    localparam int AW = $clog2(N);
`ifdef RF_DUMP_SKIP_X0_EN
    localparam int FIRST    = 1;
    localparam int DONE_CYC = 48;
`else
    localparam int FIRST    = 0;
    localparam int DONE_CYC = 49;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    logic          we3, we4;
    logic [AW-1:0] wa3, wa4;
    logic [W-1:0]  wd3, wd4;
    logic [W-1:0]  rf [N];
    logic [W-1:0]  exp_mem [N];
    int            rdy_mode;

    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    rf_dump_ctrl_if #(.WIDTH(W), .AW(AW)) bus ();

    rf_dump_ctrl #(.WIDTH(W), .NREGS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we3 && wa3 != '0) rf[wa3] <= wd3;
        if (we4 && wa4 != '0) rf[wa4] <= wd4;
    end
    assign bus.rd1 = (bus.ra1 == '0) ? '0 : rf[bus.ra1];
    assign bus.rd2 = (bus.ra2 == '0) ? '0 : rf[bus.ra2];

    // mode 0: always ready, 1: toggle every cycle
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.out_ready = ~bus.out_ready;
            else               bus.out_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic  stalled;
        word_t held;
        word_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_addr_stable", bus.out_addr, held.a);
                    check("stall_data_stable", bus.out_data, held.d);
                end
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got addr %0d data %0h, expected no word", bus.out_addr, bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("word_addr", bus.out_addr, e.a);
                        check("word_data", bus.out_data, e.d);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held.a  = bus.out_addr;
                    held.d  = bus.out_data;
                end
            end else begin
                stalled = 1'b0;
            end
            if (done) check("done_with_words_pending", sb.size(), 0);
        end
    end

    function automatic logic [W-1:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 1) return 32'h4242_4242;
        if (i == 2) return 32'hdead_beef;
        return {b, ~b, 8'h5A, b};
    endfunction

    task automatic push_expected();
        word_t w;
        for (int i = FIRST; i < N; i++) begin
            w.a = AW'(i);
            w.d = exp_mem[i];
            sb.push_back(w);
        end
    endtask

    // Starts a dump and returns at the negedge of the DONE cycle; inj pulses start mid-dump,
    // wr_x3 writes x3 while pair 2/3 is being sent.
    task automatic run_dump(input bit chk_t, input int inj, input bit wr_x3);
        int cnt;
        bit got;
        bit wrote;
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        cnt   = 0;
        got   = 1'b0;
        wrote = 1'b0;
        while (!got && cnt < 1000) begin
            @(posedge clk);
            cnt++;
            #1;
            start = (cnt == inj);
            we3   = 1'b0;
            @(negedge clk);
            if (wr_x3 && !wrote && bus.out_valid && bus.out_addr == AW'(2)) begin
                we3        = 1'b1;
                wa3        = AW'(3);
                wd3        = 32'h1234_5678;
                wrote      = 1'b1;
                exp_mem[3] = 32'h1234_5678;
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL dump_timeout: got no done after %0d cycles, expected done", cnt);
        end else if (chk_t) begin
            check("done_cycle", cnt, DONE_CYC);
        end
        check("sb_empty_at_done", sb.size(), 0);
    endtask

    initial begin : stim
        int guard;
        reset = 1'b1;
        start = 1'b0;
        we3 = 1'b0; we4 = 1'b0;
        wa3 = '0;   wa4 = '0;
        wd3 = '0;   wd4 = '0;
        rdy_mode = 0;

        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ra1", bus.ra1, 0);
        check("rst_ra2", bus.ra2, 1);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_data", bus.out_data, 0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        exp_mem[0] = '0;
        for (int i = 1; i < N; i += 2) begin
            @(posedge clk);
            #1;
            we3 = 1'b1; wa3 = AW'(i); wd3 = init_val(i);
            exp_mem[i] = init_val(i);
            we4 = (i + 1 < N);
            wa4 = AW'(i + 1);
            wd4 = init_val(i + 1);
            if (i + 1 < N) exp_mem[i + 1] = init_val(i + 1);
        end
        @(posedge clk);
        #1 we3 = 1'b0; we4 = 1'b0;

        // full dump, then a second start in the IDLE cycle right after DONE
        rdy_mode = 0;
        run_dump(1'b1, 0, 1'b0);
        run_dump(1'b1, 0, 1'b0);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_busy_low", busy, 0);

        // stalled stream plus a spurious start mid-dump
        rdy_mode = 1;
        run_dump(1'b0, 10, 1'b0);
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        // write to x3 after its pair was fetched must not show up
        run_dump(1'b1, 0, 1'b1);
        repeat (2) @(negedge clk);

        // reset while pair 4/5 is in SEND1
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.out_valid && bus.out_addr == AW'(4)) && guard < 200);
        if (guard >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pair4_timeout: got no word 4, expected it within 200 cycles");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_out_addr", bus.out_addr, 0);
        check("midrst_ra1", bus.ra1, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("no_resume_after_reset", bus.out_valid, 0);
        check("no_done_after_reset", done, 0);

        // restart from address 0, now showing the new x3 value
        run_dump(1'b1, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
